// File: rtl/base_router_pkg.sv
// Shared types and helpers for the 5-port XY mesh router tile.
// Port numbering, header field positions, XY route decision and round-robin pick.
package base_router_pkg;

  localparam int NP     = 5;
  localparam int FLIT_W = 32;

  localparam int DEST_X_MSB = 31;
  localparam int DEST_X_LSB = 28;
  localparam int DEST_Y_MSB = 27;
  localparam int DEST_Y_LSB = 24;

  typedef enum logic [2:0] {
    P_EAST  = 3'd0,
    P_NORTH = 3'd1,
    P_WEST  = 3'd2,
    P_SOUTH = 3'd3,
    P_LOCAL = 3'd4
  } port_e;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef struct packed {
    logic  hit;
    port_e idx;
  } rr_pick_t;

  // Dimension-order routing: resolve X first, then Y, otherwise deliver locally.
  function automatic port_e xy_route(input flit_t pkt, input logic [3:0] x, input logic [3:0] y);
    logic [3:0] destX;
    logic [3:0] destY;
    destX = pkt[DEST_X_MSB:DEST_X_LSB];
    destY = pkt[DEST_Y_MSB:DEST_Y_LSB];
    if (destX > x)      return P_EAST;
    else if (destX < x) return P_WEST;
    else if (destY > y) return P_NORTH;
    else if (destY < y) return P_SOUTH;
    else                return P_LOCAL;
  endfunction

  // Round-robin pick: the requester nearest after 'last' wins; 'last' itself ranks lowest.
  // Scanning far-to-near lets the nearest hit overwrite earlier ones.
  function automatic rr_pick_t rr_pick(input logic [NP-1:0] req, input port_e last);
    rr_pick_t   r;
    int         cand;
    logic [2:0] c3;
    r.hit = 1'b0;
    r.idx = last;
    for (int k = NP; k >= 1; k--) begin
      cand = (int'(last) + k) % NP;
      c3   = 3'(cand);
      if (req[c3]) begin
        r.hit = 1'b1;
        r.idx = port_e'(c3);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/base_router_if.sv
// Per-port handshake bundle of the router tile: upstream req/gnt/full in, downstream req/gnt/full out.
// 'slave' is the router side, 'master' is the surrounding mesh / testbench.
interface base_router_if;
  logic        eastReqUpStr,  northReqUpStr,  westReqUpStr,  southReqUpStr,  localReqUpStr;
  logic        eastDnStrFull, northDnStrFull, westDnStrFull, southDnStrFull, localDnStrFull;
  logic        eastGntDnStr,  northGntDnStr,  westGntDnStr,  southGntDnStr,  localGntDnStr;
  logic [31:0] eastPacketIn,  northPacketIn,  westPacketIn,  southPacketIn,  localPacketIn;
  logic        eastReqDnStr,  northReqDnStr,  westReqDnStr,  southReqDnStr,  localReqDnStr;
  logic        eastUpStrFull, northUpStrFull, westUpStrFull, southUpStrFull, localUpStrFull;
  logic        eastGntUpStr,  northGntUpStr,  westGntUpStr,  southGntUpStr,  localGntUpStr;
  logic [31:0] eastPacketOut, northPacketOut, westPacketOut, southPacketOut, localPacketOut;

  modport slave (
    input  eastReqUpStr,  northReqUpStr,  westReqUpStr,  southReqUpStr,  localReqUpStr,
    input  eastDnStrFull, northDnStrFull, westDnStrFull, southDnStrFull, localDnStrFull,
    input  eastGntDnStr,  northGntDnStr,  westGntDnStr,  southGntDnStr,  localGntDnStr,
    input  eastPacketIn,  northPacketIn,  westPacketIn,  southPacketIn,  localPacketIn,
    output eastReqDnStr,  northReqDnStr,  westReqDnStr,  southReqDnStr,  localReqDnStr,
    output eastUpStrFull, northUpStrFull, westUpStrFull, southUpStrFull, localUpStrFull,
    output eastGntUpStr,  northGntUpStr,  westGntUpStr,  southGntUpStr,  localGntUpStr,
    output eastPacketOut, northPacketOut, westPacketOut, southPacketOut, localPacketOut
  );

  modport master (
    output eastReqUpStr,  northReqUpStr,  westReqUpStr,  southReqUpStr,  localReqUpStr,
    output eastDnStrFull, northDnStrFull, westDnStrFull, southDnStrFull, localDnStrFull,
    output eastGntDnStr,  northGntDnStr,  westGntDnStr,  southGntDnStr,  localGntDnStr,
    output eastPacketIn,  northPacketIn,  westPacketIn,  southPacketIn,  localPacketIn,
    input  eastReqDnStr,  northReqDnStr,  westReqDnStr,  southReqDnStr,  localReqDnStr,
    input  eastUpStrFull, northUpStrFull, westUpStrFull, southUpStrFull, localUpStrFull,
    input  eastGntUpStr,  northGntUpStr,  westGntUpStr,  southGntUpStr,  localGntUpStr,
    input  eastPacketOut, northPacketOut, westPacketOut, southPacketOut, localPacketOut
  );
endinterface

// File: rtl/br_in_fifo.sv
// Single-clock DEPTH x 32 input FIFO with a first-word-fall-through head.
// The owner guarantees wrEn only when not full and rdEn only when not empty.
module br_in_fifo
  import base_router_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  wrEn,
  input  flit_t wrData,
  input  logic  rdEn,
  output flit_t rdData,
  output logic  full,
  output logic  empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  flit_t         mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;

  // NOTE: the storage array has no reset; pointers and count alone define emptiness,
  // so the array can map onto reset-less flops or RAM.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= wrData;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (rdEn) rdPtr <= rdPtr + 1'b1;
      case ({wrEn, rdEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign rdData = mem[rdPtr];

endmodule

// File: rtl/base_router.sv
// 5-port XY mesh router tile: per-input FIFOs, per-output round-robin arbiter and output register.
// A head flit moves from its FIFO into a free output register in a single edge.
module base_router
  import base_router_pkg::*;
#(
  parameter int unsigned x     = 1,
  parameter int unsigned y     = 1,
  parameter int unsigned DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  base_router_if.slave bus
);
  localparam logic [3:0] X_C = 4'(x);
  localparam logic [3:0] Y_C = 4'(y);

  logic [NP-1:0] reqUpStr, dnStrFull, gntDnStr;
  logic [NP-1:0] reqDnStr, upStrFull, gntUpStr;
  flit_t         packetIn  [NP];
  flit_t         packetOut [NP];

  flit_t         head  [NP];
  logic [NP-1:0] empty;
  logic [NP-1:0] pop;
  port_e         route [NP];
  logic [NP-1:0][NP-1:0] grant;   // grant[output][input]

  assign reqUpStr  = {bus.localReqUpStr,  bus.southReqUpStr,  bus.westReqUpStr,  bus.northReqUpStr,  bus.eastReqUpStr};
  assign dnStrFull = {bus.localDnStrFull, bus.southDnStrFull, bus.westDnStrFull, bus.northDnStrFull, bus.eastDnStrFull};
  assign gntDnStr  = {bus.localGntDnStr,  bus.southGntDnStr,  bus.westGntDnStr,  bus.northGntDnStr,  bus.eastGntDnStr};

  assign packetIn[P_EAST]  = bus.eastPacketIn;
  assign packetIn[P_NORTH] = bus.northPacketIn;
  assign packetIn[P_WEST]  = bus.westPacketIn;
  assign packetIn[P_SOUTH] = bus.southPacketIn;
  assign packetIn[P_LOCAL] = bus.localPacketIn;

  // Full is sampled from state before any same-cycle pop; reset also forces the grant low.
  assign gntUpStr = reqUpStr & ~upStrFull & {NP{rst}};

  for (genvar i = 0; i < NP; i++) begin : g_in
    br_in_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wrEn   (gntUpStr[i]),
      .wrData (packetIn[i]),
      .rdEn   (pop[i]),
      .rdData (head[i]),
      .full   (upStrFull[i]),
      .empty  (empty[i])
    );
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < NP; i++) route[i] = P_LOCAL;
    for (int i = 0; i < NP; i++) route[i] = xy_route(head[i], X_C, Y_C);
  end

  // Each input targets exactly one output, so at most one grant per input can be set.
  always_comb begin
    pop = '0;
    for (int o = 0; o < NP; o++) pop = pop | grant[o];
  end

  for (genvar o = 0; o < NP; o++) begin : g_out
    logic          outValid;
    flit_t         outData;
    logic          outFree;
    logic          xfer;
    logic [NP-1:0] cand;
    logic [NP-1:0] win;
    port_e         lastWin;
    rr_pick_t      pick;

    assign xfer    = outValid & gntDnStr[o] & ~dnStrFull[o];
    assign outFree = ~outValid | xfer;

    always_comb begin
      cand = '0;
      win  = '0;
      for (int i = 0; i < NP; i++) begin
        cand[i] = outFree & ~empty[i] & (route[i] == port_e'(o));
      end
      pick = rr_pick(cand, lastWin);
      for (int i = 0; i < NP; i++) begin
        win[i] = pick.hit & (pick.idx == port_e'(i));
      end
    end

    assign grant[o] = win;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        outValid <= 1'b0;
        outData  <= '0;
        lastWin  <= P_EAST;
      end else if (pick.hit) begin
        outValid <= 1'b1;
        outData  <= head[pick.idx];
        lastWin  <= pick.idx;
      end else if (xfer) begin
        outValid <= 1'b0;
      end
    end

    assign reqDnStr[o]  = outValid;
    assign packetOut[o] = outData;
  end

  assign bus.eastReqDnStr   = reqDnStr[P_EAST];
  assign bus.northReqDnStr  = reqDnStr[P_NORTH];
  assign bus.westReqDnStr   = reqDnStr[P_WEST];
  assign bus.southReqDnStr  = reqDnStr[P_SOUTH];
  assign bus.localReqDnStr  = reqDnStr[P_LOCAL];

  assign bus.eastUpStrFull  = upStrFull[P_EAST];
  assign bus.northUpStrFull = upStrFull[P_NORTH];
  assign bus.westUpStrFull  = upStrFull[P_WEST];
  assign bus.southUpStrFull = upStrFull[P_SOUTH];
  assign bus.localUpStrFull = upStrFull[P_LOCAL];

  assign bus.eastGntUpStr   = gntUpStr[P_EAST];
  assign bus.northGntUpStr  = gntUpStr[P_NORTH];
  assign bus.westGntUpStr   = gntUpStr[P_WEST];
  assign bus.southGntUpStr  = gntUpStr[P_SOUTH];
  assign bus.localGntUpStr  = gntUpStr[P_LOCAL];

  assign bus.eastPacketOut  = packetOut[P_EAST];
  assign bus.northPacketOut = packetOut[P_NORTH];
  assign bus.westPacketOut  = packetOut[P_WEST];
  assign bus.southPacketOut = packetOut[P_SOUTH];
  assign bus.localPacketOut = packetOut[P_LOCAL];

endmodule

// File: tb/tb_base_router.sv
// Self-checking bench for base_router at (1,1): directed scenarios plus randomized traffic
// scored against per-(input,output) FIFO-order queues derived from the XY routing rule.
module tb_base_router;
  import base_router_pkg::*;

  localparam int X = 1, Y = 1, DEPTH = 4;
  localparam int EAST = 0, NORTH = 1, WEST = 2, SOUTH = 3, LOC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [NP-1:0] reqUp  = '0;
  logic [NP-1:0] gntDn  = '1;
  logic [NP-1:0] dnFull = '0;
  logic [31:0]   pktIn [NP];
  logic [NP-1:0] reqDn, upFull, gntUp;
  logic [31:0]   pktOut [NP];

  int checks   = 0;
  int failures = 0;
  int seq      = 0;

  logic [31:0]   srcQ  [NP][$];
  logic [31:0]   expQ  [NP*NP][$];
  logic [31:0]   seenQ [NP][$];
  int            orderQ[NP][$];
  logic [NP-1:0] accIn    = '0;
  logic [NP-1:0] leaves   = '0;
  logic [NP-1:0] holdPrev = '0;
  logic [31:0]   holdData [NP];

  base_router_if ifc();

  base_router #(.x(X), .y(Y), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  assign ifc.eastReqUpStr  = reqUp[EAST];  assign ifc.eastPacketIn  = pktIn[EAST];
  assign ifc.northReqUpStr = reqUp[NORTH]; assign ifc.northPacketIn = pktIn[NORTH];
  assign ifc.westReqUpStr  = reqUp[WEST];  assign ifc.westPacketIn  = pktIn[WEST];
  assign ifc.southReqUpStr = reqUp[SOUTH]; assign ifc.southPacketIn = pktIn[SOUTH];
  assign ifc.localReqUpStr = reqUp[LOC];   assign ifc.localPacketIn = pktIn[LOC];
  assign ifc.eastGntDnStr  = gntDn[EAST];  assign ifc.eastDnStrFull  = dnFull[EAST];
  assign ifc.northGntDnStr = gntDn[NORTH]; assign ifc.northDnStrFull = dnFull[NORTH];
  assign ifc.westGntDnStr  = gntDn[WEST];  assign ifc.westDnStrFull  = dnFull[WEST];
  assign ifc.southGntDnStr = gntDn[SOUTH]; assign ifc.southDnStrFull = dnFull[SOUTH];
  assign ifc.localGntDnStr = gntDn[LOC];   assign ifc.localDnStrFull = dnFull[LOC];
  assign reqDn[EAST]  = ifc.eastReqDnStr;  assign pktOut[EAST]  = ifc.eastPacketOut;
  assign reqDn[NORTH] = ifc.northReqDnStr; assign pktOut[NORTH] = ifc.northPacketOut;
  assign reqDn[WEST]  = ifc.westReqDnStr;  assign pktOut[WEST]  = ifc.westPacketOut;
  assign reqDn[SOUTH] = ifc.southReqDnStr; assign pktOut[SOUTH] = ifc.southPacketOut;
  assign reqDn[LOC]   = ifc.localReqDnStr; assign pktOut[LOC]   = ifc.localPacketOut;
  assign upFull[EAST]  = ifc.eastUpStrFull;  assign gntUp[EAST]  = ifc.eastGntUpStr;
  assign upFull[NORTH] = ifc.northUpStrFull; assign gntUp[NORTH] = ifc.northGntUpStr;
  assign upFull[WEST]  = ifc.westUpStrFull;  assign gntUp[WEST]  = ifc.westGntUpStr;
  assign upFull[SOUTH] = ifc.southUpStrFull; assign gntUp[SOUTH] = ifc.southGntUpStr;
  assign upFull[LOC]   = ifc.localUpStrFull; assign gntUp[LOC]   = ifc.localGntUpStr;

  always #5 clk = ~clk;

  // Reference routing rule written straight from the XY description.
  function automatic int tb_route(input logic [31:0] p);
    int dx, dy;
    dx = int'(p[31:28]);
    dy = int'(p[27:24]);
    if (dx > X) return EAST;
    if (dx < X) return WEST;
    if (dy > Y) return NORTH;
    if (dy < Y) return SOUTH;
    return LOC;
  endfunction

  function automatic bit model_empty();
    for (int p = 0; p < NP; p++) if (srcQ[p].size() != 0) return 1'b0;
    for (int i = 0; i < NP*NP; i++) if (expQ[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      reqUp[p] = (srcQ[p].size() != 0);
      pktIn[p] = reqUp[p] ? srcQ[p][0] : 32'h0;
    end
  endtask

  // Sample at the falling edge: record accepted inputs, score departing flits, check hold-stability.
  task automatic wait_sample();
    bit found;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      accIn[p]  = reqUp[p] && gntUp[p];
      leaves[p] = reqDn[p] && gntDn[p] && !dnFull[p];
    end
    checks++;
    if (gntUp !== (reqUp & ~upFull)) begin
      failures++;
      $display("FAIL gnt_rule got=%b expected=%b", gntUp, reqUp & ~upFull);
    end
    for (int p = 0; p < NP; p++) begin
      if (holdPrev[p]) begin
        checks++;
        if (reqDn[p] !== 1'b1 || pktOut[p] !== holdData[p]) begin
          failures++;
          $display("FAIL hold_stable out=%0d got req=%b data=%h expected req=1 data=%h",
                   p, reqDn[p], pktOut[p], holdData[p]);
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (accIn[p]) expQ[p*NP + tb_route(pktIn[p])].push_back(pktIn[p]);
    end
    for (int p = 0; p < NP; p++) begin
      if (leaves[p]) begin
        found = 1'b0;
        for (int s = 0; s < NP; s++) begin
          if (!found && expQ[s*NP+p].size() != 0 && expQ[s*NP+p][0] === pktOut[p]) begin
            void'(expQ[s*NP+p].pop_front());
            orderQ[p].push_back(s);
            found = 1'b1;
          end
        end
        seenQ[p].push_back(pktOut[p]);
        checks++;
        if (!found) begin
          failures++;
          $display("FAIL scoreboard out=%0d got=%h expected the oldest pending flit of some input routed here",
                   p, pktOut[p]);
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      holdPrev[p] = reqDn[p] && !leaves[p];
      holdData[p] = pktOut[p];
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) if (accIn[p]) void'(srcQ[p].pop_front());
    accIn = '0;
    drive();
  endtask

  task automatic tick();
    wait_sample();
    advance();
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input int budget);
    int n;
    gntDn  = '1;
    dnFull = '0;
    n      = 0;
    while (!model_empty() && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!model_empty()) begin
      failures++;
      $display("FAIL drain_timeout got=flits_pending expected=all_delivered within %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int p = 0; p < NP; p++) begin
      srcQ[p].delete();
      seenQ[p].delete();
      orderQ[p].delete();
      pktIn[p] = 32'h0;
    end
    for (int i = 0; i < NP*NP; i++) expQ[i].delete();
    holdPrev = '0;
    accIn    = '0;
    reqUp    = '0;
    gntDn    = '1;
    dnFull   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] orData;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      reqUp  = NP'($urandom);
      gntDn  = NP'($urandom);
      dnFull = NP'($urandom);
      for (int p = 0; p < NP; p++) pktIn[p] = $urandom;
      @(negedge clk);
      orData = pktOut[0] | pktOut[1] | pktOut[2] | pktOut[3] | pktOut[4];
      checks++;
      if ({reqDn, upFull, gntUp} !== '0 || orData !== 32'h0) begin
        failures++;
        $display("FAIL reset_outputs got req=%b full=%b gnt=%b data_or=%h expected all zero",
                 reqDn, upFull, gntUp, orData);
      end
      @(posedge clk);
      #1;
    end
    reqUp  = '0;
    gntDn  = '1;
    dnFull = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (upFull !== '0 || reqDn !== '0) begin
      failures++;
      $display("FAIL reset_release got full=%b req=%b expected 0/0", upFull, reqDn);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_local();
    logic [31:0] pkt;
    pkt = 32'h51bbbbbb;
    srcQ[LOC].push_back(pkt);
    drive();
    wait_sample();
    checks++;
    if (gntUp[LOC] !== 1'b1) begin
      failures++;
      $display("FAIL local_gnt got=%b expected=1", gntUp[LOC]);
    end
    advance();
    wait_sample();
    checks++;
    if (reqDn !== '0) begin
      failures++;
      $display("FAIL local_latency_early got req=%b expected 00000", reqDn);
    end
    advance();
    wait_sample();
    checks++;
    if (reqDn !== 5'b00001 || pktOut[EAST] !== pkt) begin
      failures++;
      $display("FAIL local_to_east got req=%b data=%h expected req=00001 data=%h", reqDn, pktOut[EAST], pkt);
    end
    advance();
    drain(50);
  endtask

  task automatic test_back_to_back();
    srcQ[WEST].push_back(32'h6ccccccc);
    srcQ[WEST].push_back(32'h7ddddddd);
    drive();
    tick();
    tick();
    wait_sample();
    checks++;
    if (reqDn[EAST] !== 1'b1 || pktOut[EAST] !== 32'h6ccccccc) begin
      failures++;
      $display("FAIL b2b_first got req=%b data=%h expected req=1 data=6ccccccc", reqDn[EAST], pktOut[EAST]);
    end
    advance();
    wait_sample();
    checks++;
    if (reqDn[EAST] !== 1'b1 || pktOut[EAST] !== 32'h7ddddddd) begin
      failures++;
      $display("FAIL b2b_second got req=%b data=%h expected req=1 data=7ddddddd", reqDn[EAST], pktOut[EAST]);
    end
    advance();
    drain(50);
  endtask

  task automatic test_routes();
    logic [31:0] pk [4];
    int          outs [4];
    pk[0] = 32'h15aa0001; outs[0] = NORTH;
    pk[1] = 32'h10aa0002; outs[1] = SOUTH;
    pk[2] = 32'h11aa0003; outs[2] = LOC;
    pk[3] = 32'h01aa0004; outs[3] = WEST;
    for (int p = 0; p < NP; p++) seenQ[p].delete();
    for (int i = 0; i < 4; i++) srcQ[LOC].push_back(pk[i]);
    drive();
    drain(50);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seenQ[outs[i]].size() != 1 || seenQ[outs[i]][0] !== pk[i]) begin
        failures++;
        $display("FAIL route_%0d got count=%0d on out %0d expected exactly %h", i,
                 seenQ[outs[i]].size(), outs[i], pk[i]);
      end
    end
  endtask

  task automatic test_contention();
    int expOrder [4];
    expOrder[0] = NORTH; expOrder[1] = SOUTH; expOrder[2] = LOC; expOrder[3] = EAST;
    do_reset();
    srcQ[EAST].push_back(32'h51c00000);
    srcQ[NORTH].push_back(32'h51c00001);
    srcQ[SOUTH].push_back(32'h51c00003);
    srcQ[LOC].push_back(32'h51c00004);
    drive();
    drain(50);
    checks++;
    if (orderQ[EAST].size() != 4) begin
      failures++;
      $display("FAIL contention_count got=%0d expected=4", orderQ[EAST].size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (orderQ[EAST][i] != expOrder[i]) begin
          failures++;
          $display("FAIL contention_order slot=%0d got src=%0d expected src=%0d", i, orderQ[EAST][i], expOrder[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] sent [$];
    int          accepted;
    seenQ[EAST].delete();
    dnFull[EAST] = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      srcQ[WEST].push_back(32'h7e000000 | i);
      sent.push_back(32'h7e000000 | i);
    end
    drive();
    accepted = 0;
    for (int c = 0; c < 12; c++) begin
      wait_sample();
      if (accIn[WEST]) accepted++;
      advance();
    end
    wait_sample();
    checks++;
    if (upFull[WEST] !== 1'b1 || gntUp[WEST] !== 1'b0) begin
      failures++;
      $display("FAIL bp_full got full=%b gnt=%b expected full=1 gnt=0", upFull[WEST], gntUp[WEST]);
    end
    checks++;
    if (reqDn[EAST] !== 1'b1 || pktOut[EAST] !== sent[0]) begin
      failures++;
      $display("FAIL bp_held got req=%b data=%h expected req=1 data=%h", reqDn[EAST], pktOut[EAST], sent[0]);
    end
    checks++;
    if (accepted != DEPTH + 1) begin
      failures++;
      $display("FAIL bp_accepted got=%0d expected=%0d", accepted, DEPTH + 1);
    end
    advance();
    drain(60);
    checks++;
    if (seenQ[EAST].size() != sent.size()) begin
      failures++;
      $display("FAIL bp_drain_count got=%0d expected=%0d", seenQ[EAST].size(), sent.size());
    end else begin
      for (int i = 0; i < sent.size(); i++) begin
        checks++;
        if (seenQ[EAST][i] !== sent[i]) begin
          failures++;
          $display("FAIL bp_drain_order idx=%0d got=%h expected=%h", i, seenQ[EAST][i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] pkt;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        gntDn[p]  = ($urandom_range(0, 3) != 0);
        dnFull[p] = ($urandom_range(0, 3) == 0);
        if (srcQ[p].size() < 3 && $urandom_range(0, 1) == 1) begin
          pkt = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)), 4'(p), 20'(seq)};
          seq++;
          srcQ[p].push_back(pkt);
        end
      end
      drive();
      tick();
    end
    drain(300);
  endtask

  task automatic test_reset_mid();
    dnFull = '1;
    for (int p = 0; p < NP; p++) begin
      srcQ[p].push_back(32'h22000000 | p);
      srcQ[p].push_back(32'h00000100 | p);
    end
    drive();
    settle(4);
    rst = 1'b0;
    #1;
    checks++;
    if ({reqDn, upFull, gntUp} !== '0 || pktOut[EAST] !== 32'h0 || pktOut[LOC] !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_async got req=%b full=%b gnt=%b expected all zero", reqDn, upFull, gntUp);
    end
    do_reset();
    for (int c = 0; c < 8; c++) begin
      wait_sample();
      checks++;
      if (reqDn !== '0 || upFull !== '0) begin
        failures++;
        $display("FAIL reset_mid_after got req=%b full=%b expected 0/0", reqDn, upFull);
      end
      advance();
    end
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      pktIn[p]    = 32'h0;
      holdData[p] = 32'h0;
    end
    test_reset();
    test_single_local();
    test_back_to_back();
    test_routes();
    test_contention();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
